// File: rtl/sync_updown_counter.sv
// Parametrised up/down modulus counter with load and registered terminal count.
// Define SYNC_UPDOWN_COUNTER_SATURATE_EN to hold at the limits instead of wrapping.
module sync_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("sync_updown_counter: WIDTH out of range");
    end

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_mod
        $error("sync_updown_counter: MODULUS out of range");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             at_top, at_bot;

    assign at_top = (q_q == MAX);
    assign at_bot = (q_q == '0);

    // Next-state: load beats count; a step past either limit is a boundary event.
    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (load) begin
            q_d = (d > MAX) ? MAX : d;
        end else if (en) begin
            if (up && !at_top) begin
                q_d = q_q + 1'b1;
            end else if (!up && !at_bot) begin
                q_d = q_q - 1'b1;
            end else begin
                tc_d = 1'b1;
`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
                q_d  = q_q;
`else
                q_d  = up ? '0 : MAX;
`endif
            end
        end
    end

    // Count and terminal-count registers; reset clears both at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign q  = q_q;
    assign tc = tc_q;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed bench for sync_updown_counter: a 3-bit/mod-8 and a 4-bit/mod-10 instance.
// Expected values follow the build mode (wrap or saturate).
module tb_sync_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en8 = 0, up8 = 0, ld8 = 0;
    logic [2:0] d8 = '0, q8;
    logic       tc8;
    logic       en10 = 0, up10 = 0, ld10 = 0;
    logic [3:0] d10 = '0, q10;
    logic       tc10;

    int n_cmp = 0;
    int n_err = 0;

`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
    int dn_q[9]   = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    int dn_tc[9]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    int up_q[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
    int up_tc[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    int clamp_nq  = 9;
    int st_q[4]   = '{7, 7, 7, 7};
    int st_tc[4]  = '{0, 1, 1, 1};
    int st_down   = 6;
`else
    int dn_q[9]   = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int dn_tc[9]  = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
    int up_q[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int up_tc[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int clamp_nq  = 0;
    int st_q[4]   = '{7, 0, 1, 2};
    int st_tc[4]  = '{0, 1, 0, 0};
    int st_down   = 1;
`endif

    int dir_up[5] = '{1, 1, 0, 0, 0};
    int dir_en[5] = '{1, 1, 0, 1, 1};
    int dir_q[5]  = '{4, 5, 5, 4, 3};

    sync_updown_counter #(.WIDTH(3), .MODULUS(8)) u8 (
        .clk (clk),
        .rst (rst),
        .en  (en8),
        .up  (up8),
        .load(ld8),
        .d   (d8),
        .q   (q8),
        .tc  (tc8)
    );

    sync_updown_counter #(.WIDTH(4), .MODULUS(10)) u10 (
        .clk (clk),
        .rst (rst),
        .en  (en10),
        .up  (up10),
        .load(ld10),
        .d   (d10),
        .q   (q10),
        .tc  (tc10)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_q8", int'(q8), 0);
        check("rst_tc8", int'(tc8), 0);
        check("rst_q10", int'(q10), 0);
        check("rst_tc10", int'(tc10), 0);
        @(negedge clk);
        rst = 1'b1;

        // Down count on the mod-8 instance from reset
        en8 = 1'b1;
        up8 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("dn_q[%0d]", i), int'(q8), dn_q[i]);
            check($sformatf("dn_tc[%0d]", i), int'(tc8), dn_tc[i]);
        end
        en8 = 1'b0;
        check("hold_q10", int'(q10), 0);

        // Up count with short modulus
        en10 = 1'b1;
        up10 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("up_q[%0d]", i), int'(q10), up_q[i]);
            check($sformatf("up_tc[%0d]", i), int'(tc10), up_tc[i]);
        end

        // Load beats enable and clamps to the top value
        ld10 = 1'b1;
        d10  = 4'd13;
        step();
        check("clamp_q", int'(q10), 9);
        check("clamp_tc", int'(tc10), 0);
        ld10 = 1'b0;
        step();
        check("clamp_next_q", int'(q10), clamp_nq);
        check("clamp_next_tc", int'(tc10), 1);

        // Direction changes with an enable gap
        ld10 = 1'b1;
        d10  = 4'd3;
        step();
        check("ld3_q", int'(q10), 3);
        ld10 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            en10 = dir_en[i][0];
            up10 = dir_up[i][0];
            step();
            check($sformatf("dir_q[%0d]", i), int'(q10), dir_q[i]);
            check($sformatf("dir_tc[%0d]", i), int'(tc10), 0);
        end
        en10 = 1'b0;

        // Top-limit behaviour on the mod-8 instance
        ld8 = 1'b1;
        d8  = 3'd6;
        en8 = 1'b1;
        up8 = 1'b1;
        step();
        check("ld6_q", int'(q8), 6);
        check("ld6_tc", int'(tc8), 0);
        ld8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("st_q[%0d]", i), int'(q8), st_q[i]);
            check($sformatf("st_tc[%0d]", i), int'(tc8), st_tc[i]);
        end
        up8 = 1'b0;
        step();
        check("st_down_q", int'(q8), st_down);
        check("st_down_tc", int'(tc8), 0);
        en8 = 1'b0;

        // Asynchronous reset between edges, mid-count
        ld10 = 1'b1;
        d10  = 4'd5;
        step();
        check("pre_rst_q", int'(q10), 5);
        ld10 = 1'b0;
        en10 = 1'b1;
        up10 = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("arst_q10", int'(q10), 0);
        check("arst_tc10", int'(tc10), 0);
        check("arst_q8", int'(q8), 0);
        step();
        step();
        check("arst_hold_q10", int'(q10), 0);
        check("arst_hold_tc10", int'(tc10), 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("post_rst_q", int'(q10), 1);
        check("post_rst_tc", int'(tc10), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
